// File: rtl/soc_msp430_dac_spi_pkg.sv
// Shared types and constants for the MSP430 SPI DAC peripheral.
package soc_msp430_dac_spi_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LEAD,
    SHIFT_LO,
    SHIFT_HI,
    SYNC_UP,
    TRAIL_LO,
    TRAIL_HI
  } state_t;

  localparam logic [1:0] OFS_VAL  = 2'd0;
  localparam logic [1:0] OFS_CTRL = 2'd1;
  localparam logic [1:0] OFS_STAT = 2'd2;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_PEND   = 1;
  localparam int STAT_DONE   = 2;
  localparam int CTRL_IRQ_EN = 2;

  localparam int FRAME_W = 16;

endpackage

// File: rtl/soc_msp430_dac_spi_shift.sv
// SPI master FSM, half-period divider and frame shifter for the DAC.
// Frame is 36*SCLK_DIV mclk from LEAD entry; launch accepted in IDLE or at TRAIL_HI exit.
module soc_msp430_dac_spi_shift
  import soc_msp430_dac_spi_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        pending,
  input  logic [11:0] val,
  input  logic [1:0]  pd,
  output logic        launch,
  output logic        done_set,
  output logic        sclk,
  output logic        sync_n,
  output logic        din,
  output logic        busy
);

  localparam logic [7:0] DIV_M1 = 8'(SCLK_DIV - 1);

  state_t               state, state_nxt;
  logic [7:0]           cnt, cnt_nxt;
  logic [4:0]           bit_cnt, bit_nxt;
  logic [1:0]           ph, ph_nxt;
  logic [FRAME_W-1:0]   frame, frame_nxt;
  logic                 tick, reload;
  logic                 sclk_d, sync_d, din_d, busy_d;

  assign tick     = (cnt == 8'd0);
  assign launch   = pending & ((state == IDLE) | ((state == TRAIL_HI) & tick));
  assign done_set = (state == TRAIL_HI) & tick;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state   <= INIT;
      cnt     <= DIV_M1;
      bit_cnt <= 5'd0;
      ph      <= 2'd0;
      frame   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      ph      <= ph_nxt;
      frame   <= frame_nxt;
    end
  end

  // bit_cnt wraps below zero after bit 0, its MSB then marks the last SHIFT_HI
  always_comb begin
    state_nxt = state;
    ph_nxt    = ph;
    bit_nxt   = bit_cnt;
    frame_nxt = frame;
    reload    = 1'b0;
    case (state)
      INIT: begin
        if (tick) begin
          if (ph == 2'd2) begin
            state_nxt = IDLE;
          end else begin
            ph_nxt = ph + 2'd1;
            reload = 1'b1;
          end
        end
      end
      IDLE:     if (pending) state_nxt = LEAD;
      LEAD:     if (tick) state_nxt = SHIFT_LO;
      SHIFT_LO: begin
        if (tick) begin
          state_nxt = SHIFT_HI;
          bit_nxt   = bit_cnt - 5'd1;
        end
      end
      SHIFT_HI: if (tick) state_nxt = bit_cnt[4] ? SYNC_UP : SHIFT_LO;
      SYNC_UP:  if (tick) state_nxt = TRAIL_LO;
      TRAIL_LO: if (tick) state_nxt = TRAIL_HI;
      TRAIL_HI: if (tick) state_nxt = pending ? LEAD : IDLE;
      default:  state_nxt = INIT;
    endcase
    if (launch) begin
      frame_nxt = {2'b00, pd, val};
      bit_nxt   = 5'd15;
    end
    if ((state_nxt != state) || reload) begin
      cnt_nxt = DIV_M1;
    end else if (!tick) begin
      cnt_nxt = cnt - 8'd1;
    end else begin
      cnt_nxt = cnt;
    end
  end

  // Outputs are computed for the upcoming state so they register in step with it
  always_comb begin
    sclk_d = 1'b1;
    sync_d = 1'b1;
    din_d  = 1'b0;
    busy_d = 1'b1;
    case (state_nxt)
      INIT:     sclk_d = (ph_nxt != 2'd1);
      IDLE:     busy_d = 1'b0;
      LEAD: begin
        sync_d = 1'b0;
        din_d  = frame_nxt[FRAME_W-1];
      end
      SHIFT_LO: begin
        sclk_d = 1'b0;
        sync_d = 1'b0;
        din_d  = din;
      end
      SHIFT_HI: begin
        sync_d = 1'b0;
        din_d  = bit_nxt[4] ? din : frame_nxt[bit_nxt[3:0]];
      end
      TRAIL_LO: sclk_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      sclk   <= 1'b1;
      sync_n <= 1'b1;
      din    <= 1'b0;
      busy   <= 1'b1;
    end else begin
      sclk   <= sclk_d;
      sync_n <= sync_d;
      din    <= din_d;
      busy   <= busy_d;
    end
  end

endmodule

// File: rtl/soc_msp430_dac_spi.sv
// openMSP430 peripheral driving a 12-bit SPI DAC; reads are combinational, writes never stall.
// A one-deep pending buffer queues the next sample; optional interrupt under DAC_IRQ_EN.
module soc_msp430_dac_spi
  import soc_msp430_dac_spi_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR = 14'h00C8,
  parameter int unsigned SCLK_DIV  = 4
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        sclk,
  output logic        sync_n,
  output logic        din,
  output logic        dac_busy,
  output logic        irq_dac
);

  logic [13:0] addr_ofs;
  logic [1:0]  reg_ofs;
  logic        sel, wr, rd;
  logic        wr_val, wr_ctrl, wr_stat;
  logic [11:0] val;
  logic [1:0]  pd;
  logic        pending, done, irq_en;
  logic        launch, done_set;
  logic        unused_bits;

  assign addr_ofs = per_addr - BASE_ADDR;
  assign reg_ofs  = addr_ofs[1:0];
  assign sel      = per_en & (per_addr >= BASE_ADDR) & (per_addr <= (BASE_ADDR + 14'd2));
  assign wr       = sel & (|per_we);
  assign rd       = sel & ~(|per_we);
  assign wr_val   = wr & (reg_ofs == OFS_VAL);
  assign wr_ctrl  = wr & (reg_ofs == OFS_CTRL);
  assign wr_stat  = wr & (reg_ofs == OFS_STAT);

  assign unused_bits = ^{per_din[15:12], addr_ofs[13:2]};

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      val <= 12'h000;
      pd  <= 2'b00;
    end else begin
      if (wr_val && per_we[0]) val[7:0]  <= per_din[7:0];
      if (wr_val && per_we[1]) val[11:8] <= per_din[11:8];
      if (wr_ctrl && per_we[0]) pd <= per_din[1:0];
    end
  end

  // A write coinciding with a launch keeps the new sample queued
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      pending <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (wr_val)      pending <= 1'b1;
      else if (launch) pending <= 1'b0;
      if (done_set)    done <= 1'b1;
      else if (wr_stat && per_we[0] && per_din[STAT_DONE]) done <= 1'b0;
    end
  end

`ifdef DAC_IRQ_EN
  logic irq_q;
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_ctrl && per_we[0]) irq_en <= per_din[CTRL_IRQ_EN];
      irq_q <= done_set & irq_en;
    end
  end
  assign irq_dac = irq_q;
`else
  assign irq_en  = 1'b0;
  assign irq_dac = 1'b0;
`endif

  always_comb begin
    per_dout = 16'h0000;
    if (rd) begin
      case (reg_ofs)
        OFS_VAL:  per_dout[11:0] = val;
        OFS_CTRL: begin
          per_dout[1:0]       = pd;
          per_dout[CTRL_IRQ_EN] = irq_en;
        end
        OFS_STAT: begin
          per_dout[STAT_BUSY] = dac_busy;
          per_dout[STAT_PEND] = pending;
          per_dout[STAT_DONE] = done;
        end
        default: ;
      endcase
    end
  end

  soc_msp430_dac_spi_shift #(
    .SCLK_DIV (SCLK_DIV)
  ) u_shift (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .pending  (pending),
    .val      (val),
    .pd       (pd),
    .launch   (launch),
    .done_set (done_set),
    .sclk     (sclk),
    .sync_n   (sync_n),
    .din      (din),
    .busy     (dac_busy)
  );

endmodule

// File: tb/tb_soc_msp430_dac_spi.sv
// Bench for soc_msp430_dac_spi: register table plus frame, queueing, reset-abort and irq sequences.
module tb_soc_msp430_dac_spi;

  localparam logic [13:0] A_VAL  = 14'h00C8;
  localparam logic [13:0] A_CTRL = 14'h00C9;
  localparam logic [13:0] A_STAT = 14'h00CA;
`ifdef DAC_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        sclk, sync_n, din, dac_busy, irq_dac;

  soc_msp430_dac_spi dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .sclk     (sclk),
    .sync_n   (sync_n),
    .din      (din),
    .dac_busy (dac_busy),
    .irq_dac  (irq_dac)
  );

  always #5 mclk = ~mclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // DAC receiver model: shifts on falling sclk while sync_n low, latches on a falling edge with sync_n high
  logic [15:0] shreg = 16'h0;
  logic [15:0] frame_seen = 16'h0;
  logic [11:0] vout = 12'h0;
  int          rx_cnt = 0;
  int          falls_low = 0;
  int          falls_high = 0;
  int          n_frames = 0;
  logic [15:0] flog [0:15];

  always @(negedge sclk) begin
    if (sync_n === 1'b0) begin
      shreg = {shreg[14:0], din};
      rx_cnt++;
      falls_low++;
    end else begin
      falls_high++;
      if (rx_cnt == 16) begin
        vout       = shreg[11:0];
        frame_seen = shreg;
        flog[n_frames % 16] = shreg;
        n_frames++;
      end
      rx_cnt = 0;
    end
  end

  int   cyc = 0;
  int   t_lead = 0;
  int   t_end = 0;
  int   irq_cnt = 0;
  int   din_viol = 0;
  logic prev_sync = 1'b1, prev_busy = 1'b1, prev_din = 1'b0;

  always @(negedge mclk) begin
    cyc++;
    if (prev_sync === 1'b1 && sync_n === 1'b0) t_lead = cyc;
    if (prev_busy === 1'b1 && dac_busy === 1'b0) t_end = cyc;
    if (irq_dac === 1'b1) irq_cnt++;
    if (din !== prev_din && sclk !== 1'b1) din_viol++;
    prev_sync = sync_n;
    prev_busy = dac_busy;
    prev_din  = din;
  end

  task automatic cpu_wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
    per_en   = 1'b1;
    per_addr = a;
    per_din  = d;
    per_we   = we;
    @(negedge mclk);
    per_en = 1'b0;
    per_we = 2'b00;
  endtask

  task automatic cpu_rd(input logic en, input logic [13:0] a, output logic [15:0] d);
    per_en   = en;
    per_addr = a;
    per_we   = 2'b00;
    #1;
    d = per_dout;
    @(negedge mclk);
    per_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (3) @(negedge mclk);
    while (dac_busy !== 1'b0 && n < 3000) begin
      @(negedge mclk);
      n++;
    end
    if (dac_busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, busy=%b after %0d cycles, expected 0", name, dac_busy, n);
    end
    repeat (2) @(negedge mclk);
  endtask

  typedef struct {
    logic        en;
    logic [13:0] addr;
    logic [1:0]  we;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [0:8];
  logic [15:0] rdat;
  int          f0;

  initial begin
    tbl[0] = '{1'b1, A_CTRL, 2'b11, 16'h0003, 16'h0003};
    tbl[1] = '{1'b1, A_CTRL, 2'b10, 16'hFFFF, 16'h0003};
    tbl[2] = '{1'b1, A_CTRL, 2'b01, 16'h00FE, (IRQ ? 16'h0006 : 16'h0002)};
    tbl[3] = '{1'b0, A_CTRL, 2'b00, 16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 14'h00CB, 2'b00, 16'h0000, 16'h0000};
    tbl[5] = '{1'b1, 14'h00C7, 2'b00, 16'h0000, 16'h0000};
    tbl[6] = '{1'b1, A_CTRL, 2'b11, 16'h0001, 16'h0001};
    tbl[7] = '{1'b1, A_STAT, 2'b00, 16'h0000, 16'h0000};
    tbl[8] = '{1'b1, A_VAL, 2'b00, 16'h0000, 16'h0000};

    puc_rst  = 1'b1;
    per_en   = 1'b0;
    per_we   = 2'b00;
    per_addr = 14'h0;
    per_din  = 16'h0;
    repeat (3) @(negedge mclk);
    check("rst_sclk", {31'd0, sclk}, 32'd1);
    check("rst_sync_n", {31'd0, sync_n}, 32'd1);
    check("rst_din", {31'd0, din}, 32'd0);
    check("rst_busy", {31'd0, dac_busy}, 32'd1);
    check("rst_irq", {31'd0, irq_dac}, 32'd0);
    check("rst_dout", {16'd0, per_dout}, 32'd0);

    falls_low = 0;
    falls_high = 0;
    puc_rst = 1'b0;
    wait_idle("init_idle");
    check("init_falls_sync_hi", falls_high, 1);
    check("init_falls_sync_lo", falls_low, 0);
    check("init_busy", {31'd0, dac_busy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].we != 2'b00) cpu_wr(tbl[i].addr, tbl[i].wdata, tbl[i].we);
      cpu_rd(tbl[i].en, tbl[i].addr, rdat);
      check($sformatf("tbl[%0d]", i), {16'd0, rdat}, {16'd0, tbl[i].exp});
    end

    // Single frame, PD=01
    falls_low = 0;
    falls_high = 0;
    din_viol = 0;
    cpu_wr(A_VAL, 16'hFA5C, 2'b11);
    wait_idle("frame1");
    check("frame1_vout", {20'd0, vout}, 32'h0A5C);
    check("frame1_bits", {16'd0, frame_seen}, 32'h1A5C);
    check("frame1_len", t_end - t_lead, 144);
    check("frame1_falls_lo", falls_low, 16);
    check("frame1_falls_hi", falls_high, 1);
    cpu_rd(1'b1, A_STAT, rdat);
    check("frame1_stat_done", {16'd0, rdat}, 32'h0004);
    cpu_rd(1'b1, A_VAL, rdat);
    check("frame1_val_rd", {16'd0, rdat}, 32'h0A5C);
    cpu_wr(A_STAT, 16'h0004, 2'b11);
    cpu_rd(1'b1, A_STAT, rdat);
    check("done_w1c", {16'd0, rdat}, 32'h0000);

    // Three writes inside one frame: last write wins
    f0 = n_frames;
    cpu_wr(A_VAL, 16'h0111, 2'b11);
    repeat (10) @(negedge mclk);
    cpu_rd(1'b1, A_STAT, rdat);
    check("queue_busy", {16'd0, rdat}, 32'h0001);
    cpu_wr(A_VAL, 16'h0222, 2'b11);
    repeat (10) @(negedge mclk);
    cpu_wr(A_VAL, 16'h0333, 2'b11);
    cpu_rd(1'b1, A_STAT, rdat);
    check("queue_pending", {16'd0, rdat}, 32'h0003);
    wait_idle("queue");
    check("queue_nframes", n_frames - f0, 2);
    check("queue_f0", {16'd0, flog[f0 % 16]}, 32'h1111);
    check("queue_f1", {16'd0, flog[(f0 + 1) % 16]}, 32'h1333);
    cpu_rd(1'b1, A_STAT, rdat);
    check("queue_stat_end", {16'd0, rdat}, 32'h0004);

    // Second write lands on the launch cycle of the first
    f0 = n_frames;
    cpu_wr(A_VAL, 16'h0456, 2'b11);
    cpu_wr(A_VAL, 16'h0789, 2'b11);
    wait_idle("launch_race");
    check("race_nframes", n_frames - f0, 2);
    check("race_f0", {16'd0, flog[f0 % 16]}, 32'h1456);
    check("race_f1", {16'd0, flog[(f0 + 1) % 16]}, 32'h1789);

    // Reset during SHIFT_LO of bit 7
    falls_low = 0;
    cpu_wr(A_VAL, 16'h00F0, 2'b11);
    begin
      int n;
      n = 0;
      while (!(falls_low == 9 && sclk === 1'b0) && n < 1000) begin
        @(negedge mclk);
        n++;
      end
      check("abort_reach_bit7", falls_low, 9);
    end
    #2 puc_rst = 1'b1;
    #1;
    check("abort_sclk", {31'd0, sclk}, 32'd1);
    check("abort_sync_n", {31'd0, sync_n}, 32'd1);
    check("abort_busy", {31'd0, dac_busy}, 32'd1);
    repeat (3) @(negedge mclk);
    puc_rst = 1'b0;
    wait_idle("abort_init");
    check("abort_vout", {20'd0, vout}, 32'h0789);
    cpu_rd(1'b1, A_VAL, rdat);
    check("abort_val_rd", {16'd0, rdat}, 32'h0000);
    cpu_wr(A_VAL, 16'h0FFF, 2'b11);
    wait_idle("after_abort");
    check("after_abort_vout", {20'd0, vout}, 32'h0FFF);
    check("after_abort_bits", {16'd0, frame_seen}, 32'h0FFF);

    // Interrupt enable on, then off
    cpu_wr(A_STAT, 16'h0004, 2'b11);
    cpu_wr(A_CTRL, 16'h0004, 2'b11);
    irq_cnt = 0;
    cpu_wr(A_VAL, 16'h0123, 2'b11);
    wait_idle("irq_on");
    check("irq_on_pulses", irq_cnt, IRQ ? 1 : 0);
    cpu_rd(1'b1, A_STAT, rdat);
    check("irq_on_done", {16'd0, rdat}, 32'h0004);
    cpu_wr(A_STAT, 16'h0004, 2'b01);
    cpu_rd(1'b1, A_STAT, rdat);
    check("irq_done_clr", {16'd0, rdat}, 32'h0000);
    cpu_wr(A_CTRL, 16'h0000, 2'b11);
    irq_cnt = 0;
    cpu_wr(A_VAL, 16'h0321, 2'b11);
    wait_idle("irq_off");
    check("irq_off_pulses", irq_cnt, 0);
    check("irq_off_vout", {20'd0, vout}, 32'h0321);

    check("din_stable_sclk_lo", din_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
